excess_3_to_bcd_serial: RTL and testbench

Multi-digit Excess-3 to BCD decoder. It is the receive-side counterpart of the combinational BCD-to-Excess-3 encoder.
- Accepts one packed Excess-3 word through a valid/ready handshake.
- Converts one digit per clock, least-significant digit first, through a single shared 4-bit subtract-3 datapath.
- Presents the packed BCD word and per-digit invalid-code flags through a second valid/ready handshake.
- Sits between an Excess-3 source (link, encoder output) and BCD display/arithmetic logic.

---
 rtl/excess_3_to_bcd_serial_if.sv | 24 ++
 rtl/excess_3_to_bcd_serial.sv | 100 ++++++++++
 tb/tb_excess_3_to_bcd_serial.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/excess_3_to_bcd_serial_if.sv
// Handshake bundle for the serial Excess-3 to BCD decoder.
// Source side drives the input word; decoder side drives the result.
interface excess_3_to_bcd_serial_if #(
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   e;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   b;
   logic                  err;
   logic [DIGITS-1:0]     err_mask;

   modport master (
      output in_valid, e, out_ready,
      input  in_ready, out_valid, b, err, err_mask
   );

   modport slave (
      input  in_valid, e, out_ready,
      output in_ready, out_valid, b, err, err_mask
   );
endinterface

// File: rtl/excess_3_to_bcd_serial.sv
// Multi-digit Excess-3 to BCD decoder, one digit per clock, LSD first.
// Optional E3_STICKY_ERR_EN adds err_sticky, set by any errored delivery.
module excess_3_to_bcd_serial #(
   parameter int DIGITS = 4
) (
   input  logic clk,
   input  logic rst_n,
`ifdef E3_STICKY_ERR_EN
   output logic err_sticky,
`endif
   excess_3_to_bcd_serial_if.slave bus
);
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [4*DIGITS-1:0] r_cap;
   logic [4*DIGITS-1:0] r_b;
   logic [DIGITS-1:0]   r_mask;
   logic                r_oval;
   logic [3:0]          w_dig;
   logic                w_bad;
   logic [3:0]          w_bdig;

   // Shared subtract-3 datapath on the digit selected by the counter
   always_comb begin
      w_dig  = r_cap[{r_cnt, 2'b00} +: 4];
      w_bad  = (w_dig < 4'd3) || (w_dig > 4'd12);
      w_bdig = w_bad ? 4'd0 : (w_dig - 4'd3);
   end

   // Control FSM with registered result and output-valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_cap   <= '0;
         r_b     <= '0;
         r_mask  <= '0;
         r_oval  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_cap   <= bus.e;
                  r_b     <= '0;
                  r_mask  <= '0;
                  r_cnt   <= '0;
                  r_state <= CONV;
               end
            end
            CONV: begin
               r_b[{r_cnt, 2'b00} +: 4] <= w_bdig;
               r_mask[r_cnt]            <= w_bad;
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_oval  <= 1'b1;
                  r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  r_oval  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef E3_STICKY_ERR_EN
   logic r_sticky;

   // Latch any delivered word that carried an invalid digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sticky <= 1'b0;
      else if (r_oval && bus.out_ready && (|r_mask))
         r_sticky <= 1'b1;
   end

   assign err_sticky = r_sticky;
`endif

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_oval;
   assign bus.b         = r_b;
   assign bus.err_mask  = r_mask;
   assign bus.err       = |r_mask;
endmodule

// File: tb/tb_excess_3_to_bcd_serial.sv
// Directed bench for excess_3_to_bcd_serial with an expected-result queue.
// Covers latency, boundary/invalid codes, backpressure and async reset.
module tb_excess_3_to_bcd_serial;
   localparam int D = 4;

   typedef struct packed {
      logic [4*D-1:0] b;
      logic [D-1:0]   m;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;
   exp_t q[$];

   excess_3_to_bcd_serial_if #(.DIGITS(D)) u_if ();

`ifdef E3_STICKY_ERR_EN
   logic err_sticky;
   excess_3_to_bcd_serial #(.DIGITS(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .err_sticky (err_sticky),
      .bus        (u_if)
   );
`else
   excess_3_to_bcd_serial #(.DIGITS(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [4*D-1:0] ev);
      exp_t r;
      int   v;
      r = '0;
      for (int i = 0; i < D; i++) begin
         v = int'(ev[4*i +: 4]);
         if (v >= 3 && v <= 12) r.b[4*i +: 4] = 4'(v - 3);
         else r.m[i] = 1'b1;
      end
      return r;
   endfunction

   task automatic xfer(input logic [4*D-1:0] ev, input exp_t ex,
                       input int hold, input bit early);
      exp_t h;
      int   lat;
      @(negedge clk);
      check("in_ready_idle", 32'(u_if.in_ready), 32'd1);
      u_if.in_valid  = 1'b1;
      u_if.e         = ev;
      u_if.out_ready = early;
      q.push_back(ex);
      @(posedge clk); #1;
      u_if.in_valid = 1'b1;
      u_if.e        = 16'h2222;
      lat = 0;
      while (!u_if.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      u_if.in_valid = 1'b0;
      check("latency", 32'(lat), 32'(D));
      h = q.pop_front();
      check("b", 32'(u_if.b), 32'(h.b));
      check("err_mask", 32'(u_if.err_mask), 32'(h.m));
      check("err", 32'(u_if.err), 32'(|h.m));
      check("in_ready_hold", 32'(u_if.in_ready), 32'd0);
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            u_if.e        = 16'(i * 16'h1111);
            u_if.in_valid = 1'b1;
            @(posedge clk); #1;
            if (i == hold - 1) begin
               check("bp_valid", 32'(u_if.out_valid), 32'd1);
               check("bp_b", 32'(u_if.b), 32'(h.b));
               check("bp_mask", 32'(u_if.err_mask), 32'(h.m));
               check("bp_in_ready", 32'(u_if.in_ready), 32'd0);
            end
         end
         u_if.in_valid  = 1'b0;
         u_if.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      u_if.out_ready = 1'b0;
      check("post_valid", 32'(u_if.out_valid), 32'd0);
      check("post_in_ready", 32'(u_if.in_ready), 32'd1);
   endtask

   initial begin
      logic [4*D-1:0] rv;
      n_pass = 0;
      n_total = 0;
      rst_n = 1'b0;
      u_if.in_valid  = 1'b0;
      u_if.e         = '0;
      u_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
      check("rst_b", 32'(u_if.b), 32'd0);
      check("rst_err", 32'(u_if.err), 32'd0);
      check("rst_mask", 32'(u_if.err_mask), 32'd0);
      check("rst_in_ready", 32'(u_if.in_ready), 32'd1);
`ifdef E3_STICKY_ERR_EN
      check("rst_sticky", 32'(err_sticky), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      xfer(16'h4C83, '{b: 16'h1950, m: 4'b0000}, 0, 1'b0);
      xfer(16'hCCCC, '{b: 16'h9999, m: 4'b0000}, 0, 1'b1);
      xfer(16'h3333, '{b: 16'h0000, m: 4'b0000}, 0, 1'b0);
      xfer(16'h2D33, '{b: 16'h0000, m: 4'b1100}, 0, 1'b0);
      xfer(16'h3F33, '{b: 16'h0000, m: 4'b0100}, 0, 1'b1);
      xfer(16'h9876, '{b: 16'h6543, m: 4'b0000}, 10, 1'b0);

      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.e        = 16'h4C83;
      @(posedge clk); #1;
      u_if.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(u_if.out_valid), 32'd0);
      check("abort_b", 32'(u_if.b), 32'd0);
      check("abort_mask", 32'(u_if.err_mask), 32'd0);
      check("abort_in_ready", 32'(u_if.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(16'h5A76, '{b: 16'h2743, m: 4'b0000}, 0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         rv = 16'($urandom);
         xfer(rv, model(rv), i, 1'b0);
      end

`ifdef E3_STICKY_ERR_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("sticky_clr", 32'(err_sticky), 32'd0);
      xfer(16'h0333, '{b: 16'h0000, m: 4'b1000}, 0, 1'b0);
      check("sticky_set", 32'(err_sticky), 32'd1);
      xfer(16'h4444, '{b: 16'h1111, m: 4'b0000}, 0, 1'b0);
      check("sticky_keep", 32'(err_sticky), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("sticky_rst", 32'(err_sticky), 32'd0);
      rst_n = 1'b1;
`endif

      check("queue_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
